// File: rtl/ram8_bit_reader_pkg.sv
// -----------------------------------------------------------------------------
// ram8_reader_pkg
// Shared definitions for the RAM8 bit-serial reader:
//   state_t    - scan FSM states (IDLE, FETCH, SHIFT, DONE)
//   DEF_*      - default word width, bank depth and address width
//   cnt_width  - bit-counter width for a given word width (never below 1)
// -----------------------------------------------------------------------------
package ram8_reader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int unsigned DEF_WIDTH = 16;
   localparam int unsigned DEF_DEPTH = 8;
   localparam int unsigned DEF_AW    = 3;

   // A 1-bit word still needs a 1-bit counter to hold the value 0.
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/ram8_bit_reader_piso.sv
// -----------------------------------------------------------------------------
// piso_shift
// WIDTH-bit parallel-in / serial-out register, MSB first.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (clears the register)
//   i_load      - capture i_d (has priority over i_shift)
//   i_shift     - shift left by one, zero fill
//   i_d         - parallel load data
//   o_msb       - register MSB (the bit currently presented)
// -----------------------------------------------------------------------------
module piso_shift #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic             i_shift,
   input  logic [WIDTH-1:0] i_d,
   output logic             o_msb
);

   logic [WIDTH-1:0] r_shreg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shreg <= '0;
      end else if (i_load) begin
         r_shreg <= i_d;
      end else if (i_shift) begin
         r_shreg <= r_shreg << 1;
      end
   end

   assign o_msb = r_shreg[WIDTH-1];

endmodule

// File: rtl/ram8_bit_reader.sv
// -----------------------------------------------------------------------------
// ram8_bit_reader
// Walks words 0..DEPTH-1 of a RAM8-style bank through its combinational read
// port and serialises each word MSB-first onto a valid/ready bit stream.
// Read-only: there is no write path to the bank.
// Ports:
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset; abandons any scan in progress
//   start      - begin a scan (only sampled in IDLE)
//   addr       - bank read address
//   rdata      - bank read data, valid in the same cycle as addr
//   bit_out    - current serial bit
//   bit_valid  - bit_out holds a valid bit
//   bit_ready  - consumer accepts bit_out at this edge
//   busy       - scan in progress
//   done       - one-cycle pulse after the final bit of the final word
// Build option:
//   RAM8_BIT_READER_PARITY_EN - append one even-parity beat (^word) after
//   each word's LSB.
// -----------------------------------------------------------------------------
module ram8_bit_reader
   import ram8_reader_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned DEPTH = DEF_DEPTH,
   parameter int unsigned AW    = DEF_AW
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] rdata,
   output logic             bit_out,
   output logic             bit_valid,
   input  logic             bit_ready,
   output logic             busy,
   output logic             done
);

   localparam int unsigned    CW        = cnt_width(WIDTH);
   localparam logic [CW-1:0]  CNT_LAST  = CW'(WIDTH - 1);
   localparam logic [AW-1:0]  ADDR_LAST = AW'(DEPTH - 1);

   state_t          r_state;
   state_t          w_next;
   logic [AW-1:0]   r_addr;
   logic [CW-1:0]   r_cnt;
   logic            r_bit_valid;

   logic            w_hs;
   logic            w_load;
   logic            w_shift;
   logic            w_word_end;
   logic            w_addr_clr;
   logic            w_addr_inc;
   logic            w_msb;

`ifdef RAM8_BIT_READER_PARITY_EN
   logic            r_parity;
   logic            r_par_phase;
   logic            w_par_enter;
`endif

   assign w_hs = r_bit_valid & bit_ready;

   // -------------------------------------------------------------------------
   // Next-state and control decode
   // -------------------------------------------------------------------------
   always_comb begin
      w_next     = r_state;
      w_load     = 1'b0;
      w_shift    = 1'b0;
      w_word_end = 1'b0;
      w_addr_clr = 1'b0;
      w_addr_inc = 1'b0;
`ifdef RAM8_BIT_READER_PARITY_EN
      w_par_enter = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            if (start) begin
               w_addr_clr = 1'b1;
               w_next     = FETCH;
            end
         end
         FETCH: begin
            w_load = 1'b1;
            w_next = SHIFT;
         end
         SHIFT: begin
            if (w_hs) begin
`ifdef RAM8_BIT_READER_PARITY_EN
               if (r_par_phase) begin
                  w_word_end = 1'b1;
               end else if (r_cnt != '0) begin
                  w_shift = 1'b1;
               end else begin
                  w_par_enter = 1'b1;
               end
`else
               if (r_cnt != '0) begin
                  w_shift = 1'b1;
               end else begin
                  w_word_end = 1'b1;
               end
`endif
               if (w_word_end) begin
                  if (r_addr == ADDR_LAST) begin
                     w_next = DONE;
                  end else begin
                     w_addr_inc = 1'b1;
                     w_next     = FETCH;
                  end
               end
            end
         end
         DONE: begin
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State, address, bit counter
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr <= '0;
      end else if (w_addr_clr) begin
         r_addr <= '0;
      end else if (w_addr_inc) begin
         r_addr <= r_addr + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_load) begin
         r_cnt <= CNT_LAST;
      end else if (w_shift) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   // Valid is registered from the next state so it is a clean flop output
   // that stays high across stalled SHIFT cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bit_valid <= 1'b0;
      end else begin
         r_bit_valid <= (w_next == SHIFT);
      end
   end

`ifdef RAM8_BIT_READER_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_parity    <= 1'b0;
         r_par_phase <= 1'b0;
      end else begin
         if (w_load) begin
            r_parity <= ^rdata;
         end
         if (w_load || w_word_end) begin
            r_par_phase <= 1'b0;
         end else if (w_par_enter) begin
            r_par_phase <= 1'b1;
         end
      end
   end
`endif

   // -------------------------------------------------------------------------
   // Serialiser
   // -------------------------------------------------------------------------
   piso_shift #(
      .WIDTH (WIDTH)
   ) u_piso (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_load),
      .i_shift (w_shift),
      .i_d     (rdata),
      .o_msb   (w_msb)
   );

`ifdef RAM8_BIT_READER_PARITY_EN
   assign bit_out = r_par_phase ? r_parity : w_msb;
`else
   assign bit_out = w_msb;
`endif

   assign addr      = r_addr;
   assign bit_valid = r_bit_valid;
   assign busy      = (r_state != IDLE);
   assign done      = (r_state == DONE);

endmodule

// File: tb/tb_ram8_bit_reader.sv
module tb_ram8_bit_reader;

   localparam int W = 16;
   localparam int D = 8;
`ifdef RAM8_BIT_READER_PARITY_EN
   localparam int BEATS = W + 1;
`else
   localparam int BEATS = W;
`endif

   typedef struct {
      logic       b;
      logic [2:0] a;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;

   // main DUT, DEPTH = 8
   logic         start, bit_ready;
   logic [2:0]   addr;
   logic [W-1:0] rdata;
   logic         bit_out, bit_valid, busy, done;
   logic [W-1:0] mem [D];

   // single-word DUT, DEPTH = 1
   logic         s1_start, s1_ready;
   logic [0:0]   s1_addr;
   logic [W-1:0] s1_rdata;
   logic         s1_bit, s1_valid, s1_busy, s1_done;

   int checks = 0;
   int errors = 0;

   exp_t sb[$];
   bit   mon_en = 1'b0;
   int   busy_cnt, done_cnt, beat_cnt;
   bit   hold_v;
   logic hold_b;
   logic [2:0] hold_a;

   always #5 clk = ~clk;

   assign rdata    = mem[addr];
   assign s1_rdata = (s1_addr == 1'b0) ? 16'hA5A5 : 16'h0000;

   ram8_bit_reader #(.WIDTH(W), .DEPTH(D), .AW(3)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .rdata(rdata),
      .bit_out(bit_out), .bit_valid(bit_valid), .bit_ready(bit_ready),
      .busy(busy), .done(done)
   );

   ram8_bit_reader #(.WIDTH(W), .DEPTH(1), .AW(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(s1_start), .addr(s1_addr), .rdata(s1_rdata),
      .bit_out(s1_bit), .bit_valid(s1_valid), .bit_ready(s1_ready),
      .busy(s1_busy), .done(s1_done)
   );

   // Scoreboard monitor for the main DUT, sampling on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (hold_v) begin
               checks++;
               if (bit_out !== hold_b || bit_valid !== 1'b1 || addr !== hold_a) begin
                  errors++;
                  $display("FAIL stall_stable: got bit=%b valid=%b addr=%0d want bit=%b valid=1 addr=%0d",
                           bit_out, bit_valid, addr, hold_b, hold_a);
               end
            end
            hold_v = bit_valid && !bit_ready;
            hold_b = bit_out;
            hold_a = addr;
            if (bit_valid && bit_ready) begin
               beat_cnt++;
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL extra_beat: got bit=%b addr=%0d want no beat", bit_out, addr);
               end else begin
                  e = sb.pop_front();
                  if (bit_out !== e.b || addr !== e.a) begin
                     errors++;
                     $display("FAIL beat %0d: got bit=%b addr=%0d want bit=%b addr=%0d",
                              beat_cnt, bit_out, addr, e.b, e.a);
                  end
               end
            end
         end
      end
   end

   function automatic void push_scan();
      exp_t e;
      logic [W-1:0] w;
      sb.delete();
      for (int i = 0; i < D; i++) begin
         w = mem[i];
         for (int b = W - 1; b >= 0; b--) begin
            e.b = w[b];
            e.a = 3'(i);
            sb.push_back(e);
         end
`ifdef RAM8_BIT_READER_PARITY_EN
         e.b = ^w;
         e.a = 3'(i);
         sb.push_back(e);
`endif
      end
   endfunction

   // Drives one scan on the main DUT. mode 0: ready held high; mode 1: ready
   // pattern 1,0,0. restart_addr >= 0 re-pulses start mid-word at that address.
   task automatic run_scan(input int mode, input int restart_addr, input bit start_in_done);
      int cyc = 0;
      bit restarted = 1'b0;
      bit got_done = 1'b0;
      busy_cnt = 0; done_cnt = 0; beat_cnt = 0; hold_v = 1'b0;
      push_scan();
      mon_en = 1'b1;
      @(posedge clk); #1;
      start = 1'b1;
      bit_ready = 1'b1;
      while (cyc < 3000) begin
         @(posedge clk); #1;
         start = 1'b0;
         bit_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
         if (restart_addr >= 0 && !restarted && addr == 3'(restart_addr) && bit_valid) begin
            start = 1'b1;
            restarted = 1'b1;
         end
         @(negedge clk);
         if (done) begin
            got_done = 1'b1;
            if (start_in_done) start = 1'b1;
            break;
         end
         cyc++;
      end
      checks++;
      if (!got_done) begin
         errors++;
         $display("FAIL scan_timeout: got no done within %0d cycles want done", cyc);
      end
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_scan: got busy=%b want 0", busy);
         end
      end
      mon_en = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if (addr !== 3'd0 || bit_out !== 1'b0 || bit_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got addr=%0d bit=%b valid=%b busy=%b done=%b want all 0",
                  addr, bit_out, bit_valid, busy, done);
      end
      checks++;
      if (s1_addr !== 1'b0 || s1_bit !== 1'b0 || s1_valid !== 1'b0 || s1_busy !== 1'b0 || s1_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_state_s1: got addr=%0d bit=%b valid=%b busy=%b done=%b want all 0",
                  s1_addr, s1_bit, s1_valid, s1_busy, s1_done);
      end
   endtask

   task automatic test_single_word();
      logic [W-1:0] word = 16'hA5A5;
      logic exp_v, exp_b;
      @(posedge clk); #1;
      s1_start = 1'b1;
      s1_ready = 1'b1;
      @(posedge clk); #1;
      s1_start = 1'b0;
      // n counts edges after the one that accepted start
      for (int n = 0; n <= BEATS + 2; n++) begin
         @(negedge clk);
         exp_v = (n >= 1 && n <= BEATS);
         checks++;
         if (s1_valid !== exp_v) begin
            errors++;
            $display("FAIL single_valid n=%0d: got %b want %b", n, s1_valid, exp_v);
         end
         if (exp_v) begin
            exp_b = (n <= W) ? word[W - n] : ^word;
            checks++;
            if (s1_bit !== exp_b) begin
               errors++;
               $display("FAIL single_bit n=%0d: got %b want %b", n, s1_bit, exp_b);
            end
         end
         checks++;
         if (s1_done !== (n == BEATS + 1)) begin
            errors++;
            $display("FAIL single_done n=%0d: got %b want %b", n, s1_done, (n == BEATS + 1));
         end
         checks++;
         if (s1_busy !== (n <= BEATS + 1)) begin
            errors++;
            $display("FAIL single_busy n=%0d: got %b want %b", n, s1_busy, (n <= BEATS + 1));
         end
      end
   endtask

   task automatic check_scan_totals(input string name, input bit check_time);
      checks++;
      if (beat_cnt !== D * BEATS || sb.size() != 0) begin
         errors++;
         $display("FAIL %s_beats: got %0d beats (%0d left) want %0d", name, beat_cnt, sb.size(), D * BEATS);
      end
      checks++;
      if (done_cnt !== 1) begin
         errors++;
         $display("FAIL %s_done_count: got %0d want 1", name, done_cnt);
      end
      if (check_time) begin
         checks++;
         if (busy_cnt !== D * (BEATS + 1) + 1) begin
            errors++;
            $display("FAIL %s_busy_cycles: got %0d want %0d", name, busy_cnt, D * (BEATS + 1) + 1);
         end
      end
   endtask

   task automatic test_full_scan();
      for (int i = 0; i < D; i++) mem[i] = 16'h0001 << i;
      run_scan(0, -1, 1'b0);
      check_scan_totals("full", 1'b1);
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < D; i++) mem[i] = 16'h0001 << i;
      run_scan(1, -1, 1'b0);
      check_scan_totals("bp", 1'b0);
   endtask

   task automatic test_start_busy();
      for (int i = 0; i < D; i++) mem[i] = 16'($urandom);
      run_scan(0, 3, 1'b1);
      check_scan_totals("start_busy", 1'b1);
   endtask

   task automatic test_reset_mid();
      int cyc = 0;
      for (int i = 0; i < D; i++) mem[i] = 16'hFFFF;
      busy_cnt = 0; done_cnt = 0; beat_cnt = 0; hold_v = 1'b0;
      push_scan();
      mon_en = 1'b1;
      @(posedge clk); #1;
      start = 1'b1;
      bit_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      while (!(addr == 3'd2 && bit_valid) && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      checks++;
      if (cyc >= 200) begin
         errors++;
         $display("FAIL reset_mid_reach: got addr=%0d want word 2 within 200 cycles", addr);
      end
      repeat (3) @(posedge clk);
      #2;
      mon_en = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++;
      if (addr !== 3'd0 || bit_out !== 1'b0 || bit_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_outputs: got addr=%0d bit=%b valid=%b busy=%b done=%b want all 0",
                  addr, bit_out, bit_valid, busy, done);
      end
      checks++;
      if (done_cnt !== 0) begin
         errors++;
         $display("FAIL reset_mid_done: got %0d done pulses want 0", done_cnt);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < D; i++) mem[i] = 16'hC3A0 ^ 16'(i * 16'h1111);
      run_scan(0, -1, 1'b0);
      check_scan_totals("rescan", 1'b1);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      bit_ready = 1'b0;
      s1_start = 1'b0;
      s1_ready = 1'b0;
      for (int i = 0; i < D; i++) mem[i] = '0;
      #12;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      test_single_word();
      test_full_scan();
      test_backpressure();
      test_start_busy();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ram8_bit_reader.md
Name: ram8_bit_reader

Overview:
- Read-side counterpart to the storage chain (Bit → Register → RAM8): walks all words of a RAM8-style bank through its read port.
- Serializes each word MSB-first onto a 1-bit stream with a valid/ready handshake.
- Sits between the memory bank and a bit-serial consumer, such as a debug dump or a checker that writes `.out` tables.
- Has no write path; it never drives the bank's `load`.

Parameters:
- WIDTH, 16, bits per word.
- DEPTH, 8, number of words scanned; must be ≥1.
- AW, 3, address width; must satisfy 2**AW ≥ DEPTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a scan; sampled only in IDLE.
- addr  output  AW  read address to the bank.
- rdata  input  WIDTH  bank read data; combinational from addr, valid in the same cycle.
- bit_out  output  1  current serial bit.
- bit_valid  output  1  bit_out holds a valid bit.
- bit_ready  input  1  consumer accepts bit_out at this edge.
- busy  output  1  scan in progress (state ≠ IDLE).
- done  output  1  one-cycle pulse after the last bit of the last word is accepted.

Behaviour:
- Reset (rst_n=0, takes effect immediately):
  - state=IDLE.
  - addr=0, bit_out=0, bit_valid=0, busy=0, done=0.
  - Shift register and counter cleared.
  - Reset mid-scan abandons the scan; no done pulse is produced.
- State IDLE:
  - start=1 at an edge: addr←0, state←FETCH.
  - start=0: stay in IDLE.
- State FETCH (exactly one cycle, bit_valid=0):
  - shreg←rdata.
  - cnt←WIDTH-1.
  - state←SHIFT.
- State SHIFT:
  - bit_valid=1 and bit_out=shreg[WIDTH-1], both driven directly from registers.
  - While bit_ready=0, bit_out, bit_valid and addr stay stable.
  - Handshake: bit_valid & bit_ready at an edge.
    - If cnt≠0: shreg←shreg<<1, cnt←cnt-1.
    - If cnt=0 and addr≠DEPTH-1: addr←addr+1, state←FETCH.
    - If cnt=0 and addr=DEPTH-1: state←DONE.
- State DONE: done=1 for exactly one cycle, busy=1, then state←IDLE.
- Latency: start accepted at edge k → first bit_valid after edge k+1.
- Inter-word gap: one FETCH cycle with bit_valid=0.
- Full scan duration with bit_ready held high: 1+DEPTH*(WIDTH+1)+1 cycles, measured from the start edge to the return to IDLE.
- start while busy is ignored; no queuing.
- start in the same cycle as the DONE→IDLE transition is ignored. A new scan requires start in IDLE.
- addr never exceeds DEPTH-1; no wrap-around within a scan.
- cnt width is $clog2(WIDTH); a WIDTH=1 build uses a 1-bit cnt.

Optional Feature:
- Macro RAM8_BIT_READER_PARITY_EN.
- Defined:
  - After a word's LSB is accepted, one extra SHIFT beat presents the even-parity bit (^word as fetched).
  - The next FETCH (or DONE) follows acceptance of the parity bit.
  - Each word occupies WIDTH+1 serial beats.
  - Full-scan time becomes 1+DEPTH*(WIDTH+2)+1 cycles.
- Undefined: no parity beat; no parity logic present.

Decomposition:
- Shared package ram8_reader_pkg holds:
  - State enum: IDLE, FETCH, SHIFT, DONE.
  - Default constants: WIDTH=16, DEPTH=8, AW=3.
- One natural sub-module: piso_shift, a WIDTH-bit parallel-in/serial-out register with load and shift enables and an MSB tap.
- FSM, address counter and bit counter stay in the top level.

Test Plan:
- Single word shift-out:
  - Stimulus: bank [0]=16'hA5A5, others 0; DEPTH=1; bit_ready=1; start pulse.
  - Response: bit_out sequence 1010010110100101; bit_valid first high 2 cycles after start; done pulse at cycle 18; busy low at cycle 19.
- Full scan:
  - Stimulus: bank[i]=16'h0001<<i, i=0..7; bit_ready=1.
  - Response: 128 valid beats; beat positions 15,30,45,…,120 (a single 1 per word, moving one place left each word) are 1, all others 0; addr steps 0..7; exactly one done; total 138 cycles.
- Backpressure:
  - Stimulus: bit_ready toggles 1,0,0,1,…
  - Response: bit_out/bit_valid unchanged during ready=0 cycles; the stream is identical to the full-scan case.
- start while busy:
  - Stimulus: start re-pulsed mid-word 3.
  - Response: no effect; scan completes normally; a single done pulse.
- Reset mid-scan:
  - Stimulus: rst_n=0 asynchronously (between edges) during word 2.
  - Response: all outputs 0 immediately; no done; a subsequent start rescans from addr 0.
- Parity build:
  - Stimulus: RAM8_BIT_READER_PARITY_EN defined; [0]=16'h0007.
  - Response: 17th beat = 1; next word fetched only after it is accepted.
